// File: rtl/ref_clk_sel_ctrl.sv
// ref_clk_sel_ctrl
// Control stage in front of the reference-clock divider tap decoder. It
// resynchronises the slow-control select request and waits until the request
// has been stable for several samples. Codes 5..7 are rejected. A new code is
// applied only at the /512 phase wrap, so the tap decoder never switches
// mid-period. After every switch, and after reset, ref_clk_valid is held low
// for a settle window.
`timescale 1ns/1ps

module ref_clk_sel_ctrl #(
   parameter int         STABLE_CYCLES = 4,
   parameter int         SETTLE_CYCLES = 1024,
   parameter logic [2:0] DEFAULT_SEL   = 3'd1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [2:0] sel_req,
   input  logic       err_clr,
   output logic [2:0] ref_clk_sel,
   output logic       ref_clk_valid,
   output logic       sel_busy,
   output logic       sel_changed,
   output logic       err_invalid,
   output logic [8:0] div_cnt
);

   localparam int STW = $clog2(STABLE_CYCLES + 1);
   localparam int SEW = $clog2(SETTLE_CYCLES);

   // The candidate is accepted on the sample that brings the count to STABLE_CYCLES.
   localparam logic [STW-1:0] STABLE_LAST = STW'(STABLE_CYCLES - 1);
   localparam logic [SEW-1:0] SETTLE_LAST = SEW'(SETTLE_CYCLES - 1);
   localparam logic [2:0]     MAX_CODE    = 3'd4;
   localparam logic [8:0]     DIV_LAST    = 9'd511;

   typedef enum logic [1:0] {
      IDLE,
      QUALIFY,
      WAIT_ALIGN,
      SETTLE
   } state_t;

   state_t           state;
   logic [2:0]       sync_meta;
   logic [2:0]       sel_sync;
   logic [2:0]       req_q;
   logic [2:0]       cand;
   logic [STW-1:0]   stable_cnt;
   logic [SEW-1:0]   settle_cnt;

   // Two-flop resynchroniser per request bit. Bit skew is handled later by the stability qualifier.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_meta <= DEFAULT_SEL;
         sel_sync  <= DEFAULT_SEL;
      end else begin
         sync_meta <= sel_req;
         sel_sync  <= sync_meta;
      end
   end

   // Free-running /512 phase counter. Its 511->0 wrap is the only legal switch point.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 9'd1;
      end
   end

   // Selection FSM with registered outputs. A rejection that sets err_invalid overrides err_clr in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= SETTLE;
         req_q         <= DEFAULT_SEL;
         cand          <= DEFAULT_SEL;
         stable_cnt    <= '0;
         settle_cnt    <= '0;
         ref_clk_sel   <= DEFAULT_SEL;
         ref_clk_valid <= 1'b0;
         sel_busy      <= 1'b1;
         sel_changed   <= 1'b0;
         err_invalid   <= 1'b0;
      end else begin
         sel_changed <= 1'b0;
         if (err_clr) begin
            err_invalid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (sel_sync != req_q) begin
                  cand       <= sel_sync;
                  stable_cnt <= STW'(1);
                  state      <= QUALIFY;
                  sel_busy   <= 1'b1;
               end
            end
            QUALIFY: begin
               if (sel_sync == req_q) begin
                  state    <= IDLE;
                  sel_busy <= 1'b0;
               end else if (sel_sync != cand) begin
                  cand       <= sel_sync;
                  stable_cnt <= STW'(1);
               end else begin
                  stable_cnt <= stable_cnt + 1'b1;
                  if (stable_cnt == STABLE_LAST) begin
                     req_q <= cand;
                     if (cand > MAX_CODE) begin
                        err_invalid <= 1'b1;
                        state       <= IDLE;
                        sel_busy    <= 1'b0;
                     end else if (cand == ref_clk_sel) begin
                        state    <= IDLE;
                        sel_busy <= 1'b0;
                     end else begin
                        state <= WAIT_ALIGN;
                     end
                  end
               end
            end
            WAIT_ALIGN: begin
               if (div_cnt == DIV_LAST) begin
                  ref_clk_sel   <= req_q;
                  ref_clk_valid <= 1'b0;
                  settle_cnt    <= '0;
                  sel_changed   <= 1'b1;
                  state         <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  ref_clk_valid <= 1'b1;
                  sel_busy      <= 1'b0;
                  state         <= IDLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            default: begin
               state    <= SETTLE;
               sel_busy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/ref_clk_sel_ctrl.md
# ref_clk_sel_ctrl

Upstream control stage for the reference-clock divider tap decoder. It takes the slow-control divider-select request, which is asynchronous to the fast clock. It resynchronises the request, qualifies it for multi-bit stability, and rejects illegal codes. It then applies the selection only at the /512 divider phase wrap, so the tap decoder never switches transmission gates mid-period. After each switch, and after reset, it blanks a validity flag for a settle window.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples needed to accept a request (≥2).
- SETTLE_CYCLES, 1024: clk cycles `ref_clk_valid` stays low after a switch or reset (≥2).
- DEFAULT_SEL, 3'd1: select code after reset (/256).

Ports:
- clk  in  1  fast clock being divided.
- rstn  in  1  reset, synchronous, active-low.
- sel_req  in  3  requested divider code from slow control; asynchronous, quasi-static, bits may skew.
- err_clr  in  1  clears `err_invalid`.
- ref_clk_sel  out  3  applied select code; feeds the tap decoder. Always in 0..4.
- ref_clk_valid  out  1  high when the divided clock is settled.
- sel_busy  out  1  high whenever the FSM is not in IDLE.
- sel_changed  out  1  one-cycle pulse, the cycle after `ref_clk_sel` updates.
- err_invalid  out  1  sticky flag: a qualified request was 5..7.
- div_cnt  out  9  free-running divider phase counter.

## Operation
- Synchroniser: a 2-flop synchroniser per bit of `sel_req` produces `sel_sync`. Reset value is DEFAULT_SEL.
- `div_cnt`: increments every clk and wraps 511→0. It is never stalled.
- Internal registers:
  - `req_q`: last qualified request. Reset value DEFAULT_SEL.
  - `cand`: candidate code under qualification.
  - `stable_cnt`: width $clog2(STABLE_CYCLES+1).
  - `settle_cnt`: width $clog2(SETTLE_CYCLES).
- FSM states: IDLE, QUALIFY, WAIT_ALIGN, SETTLE. Reset state is SETTLE with `settle_cnt`=0.
- IDLE: if `sel_sync` ≠ `req_q`, load `cand`=`sel_sync`, set `stable_cnt`=1, go to QUALIFY.
- QUALIFY: evaluated in priority order.
  - If `sel_sync` = `req_q`, return to IDLE (request withdrawn).
  - Else if `sel_sync` ≠ `cand`, reload `cand` and set `stable_cnt`=1.
  - Else increment `stable_cnt`. When it reaches STABLE_CYCLES, set `req_q`=`cand`, then:
    - `cand` > 4: set `err_invalid`, go to IDLE. `ref_clk_sel` is unchanged.
    - `cand` = `ref_clk_sel`: go to IDLE. No switch occurs.
    - Otherwise: go to WAIT_ALIGN.
- WAIT_ALIGN: on the edge where `div_cnt`=511:
  - `ref_clk_sel`←`req_q`, `ref_clk_valid`←0, `settle_cnt`←0.
  - Go to SETTLE.
  - `sel_changed`=1 in the following cycle.
- SETTLE: `settle_cnt` increments each cycle. When `settle_cnt`=SETTLE_CYCLES−1, go to IDLE and set `ref_clk_valid`←1.
- Input changes during WAIT_ALIGN or SETTLE are ignored. IDLE re-evaluates `sel_sync` against `req_q` on entry, so the last request is never lost.
- `err_invalid`: set by the rejection above and cleared by `err_clr`. If both happen in the same cycle, set wins.

## Timing
- Reset values of all outputs:
  - `ref_clk_sel`=DEFAULT_SEL, `ref_clk_valid`=0, `sel_busy`=1.
  - `sel_changed`=0, `err_invalid`=0, `div_cnt`=0.
- Reset is synchronous and takes priority over everything. Asserting it mid-switch aborts the switch: `ref_clk_sel` returns to DEFAULT_SEL and a full settle window follows.
- Reset release: `ref_clk_valid` rises SETTLE_CYCLES clk edges after the first edge with `rstn`=1.
- Request latency: a stable `sel_req` change reaches `sel_sync` 2 edges later. It is accepted STABLE_CYCLES−1 edges after the IDLE→QUALIFY edge.
- Switch latency: up to 512 further cycles for alignment. `ref_clk_sel` changes only on the edge where `div_cnt` goes 511→0, never elsewhere.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- `sel_busy` = (state ≠ IDLE), registered.

## Test plan
- Reset release with `sel_req`=1:
  - `ref_clk_sel`=1 throughout; `ref_clk_valid` goes 0→1 exactly 1024 edges after release.
  - `sel_changed` stays 0; `sel_busy` drops with valid.
- Set `sel_req`=3 while `div_cnt`=100:
  - `ref_clk_sel` becomes 3 at the next 511→0 edge.
  - `sel_changed` pulses once; `ref_clk_valid` is low for 1024 cycles, then high.
- Skewed request: drive `sel_req` 1→0→2 with the bits changing one cycle apart:
  - Only 2 is applied; no intermediate code ever appears on `ref_clk_sel`.
- Drive `sel_req`=6:
  - `err_invalid`=1 and `ref_clk_sel` unchanged.
  - Hold `sel_req`=6: no re-flag after `err_clr`.
  - Then `sel_req`=4: switch to 4 and `err_invalid` stays clear.
- Change `sel_req` 1→4 during SETTLE from a prior switch:
  - 4 is applied only after SETTLE completes, requalification, and the next wrap.
- Assert `rstn`=0 in WAIT_ALIGN with pending `req_q`=0:
  - Next cycle `ref_clk_sel`=1, `div_cnt`=0, FSM in SETTLE, `ref_clk_valid`=0.
